conv_layer_sequencer: RTL and testbench
=======================================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter OCH_PAR, default 4: output channels computed per group; SHALL be even and at least 2.
REQ-002 Parameter BIAS_BITS, default 16: width of one bias.
REQ-003 Parameter AXI_WIDTH_AD, default 32: DMA byte-address width.
REQ-004 Parameter AXI_WIDTH_DA, default 32: DMA data width; each beat carries two biases.
REQ-005 Parameter BITS_TRANS, default 18: width of the DMA beat count.
REQ-006 Ports SHALL be:
- clk  in  1  the single clock.
- rst  in  1  reset; synchronous, active-high.
- ap_start  in  1  one-cycle start pulse for a layer.
- out_ch  in  9  output channel count for the layer.
- bias_start_addr  in  AXI_WIDTH_AD  byte address of bias 0.
- grp_done  in  1  pulse from the datapath when the current group is finished.
- dma_din  in  AXI_WIDTH_DA  DMA read data.
- dma_din_vld  in  1  DMA beat valid.
- dma_done  in  1  DMA transfer complete pulse.
- start_dma  out  1  one-cycle DMA request.
- num_trans  out  BITS_TRANS  number of beats requested.
- start_addr  out  AXI_WIDTH_AD  DMA start byte address.
- dma_sel  out  1  1 = sequencer owns the shared DMA port.
- bias_vec  out  OCH_PAR*BIAS_BITS  group biases; lane i holds channel och_base+i.
- och_mask  out  OCH_PAR  lane valid mask.
- och_base  out  9  first channel index of the current group.
- calc_start  out  1  one-cycle start pulse for a group.
- busy  out  1  high whenever the state is not IDLE.
- ap_done  out  1  one-cycle layer-done pulse.

Function
REQ-007 The state machine SHALL have the states IDLE, BIAS_REQ, BIAS_WAIT, GRP_START, GRP_RUN, NEXT and DONE.
REQ-008 In IDLE, ap_start SHALL latch out_ch and bias_start_addr, clear the group index, and move to BIAS_REQ; if out_ch==0 it SHALL move to DONE instead.
REQ-009 BIAS_REQ SHALL last one cycle and pulse start_dma with these values:
- start_addr = base + och_base*(BIAS_BITS/8).
- num_trans = ceil(valid/2), where valid = min(OCH_PAR, out_ch-och_base).
REQ-010 dma_sel SHALL be 1 in BIAS_REQ and BIAS_WAIT only.
REQ-011 In BIAS_WAIT, each dma_din_vld beat SHALL write lanes 2k and 2k+1 (low half to lane 2k) for beat index k; beats with k>=num_trans SHALL be ignored.
REQ-012 BIAS_WAIT SHALL exit to GRP_START when dma_done has been seen and num_trans beats have been received, in either order and including the same cycle.
REQ-013 Lanes with index >= valid SHALL read zero and have a zero och_mask bit; the mask SHALL be updated in BIAS_REQ.
REQ-014 GRP_START SHALL pulse calc_start for exactly one cycle and then enter GRP_RUN.
REQ-015 bias_vec, och_mask and och_base SHALL be stable from GRP_START until the next BIAS_REQ.
REQ-016 GRP_RUN SHALL wait for grp_done; grp_done in any other state SHALL be ignored.
REQ-017 NEXT SHALL advance och_base by OCH_PAR; if the result is >= the latched out_ch it SHALL go to DONE, otherwise to BIAS_REQ.
REQ-018 DONE SHALL pulse ap_done for one cycle and return to IDLE.
REQ-019 ap_start outside IDLE SHALL be ignored.
REQ-020 Latency: ap_start at cycle T gives start_dma at T+1; the final dma_done or beat at cycle U gives calc_start at U+1; grp_done at cycle V on the last group gives ap_done at V+2.
REQ-021 The next group's request SHALL be issued at V+2 after a non-final grp_done at V.
REQ-022 Address arithmetic SHALL be unsigned at AXI_WIDTH_AD bits and wrap modulo 2^AXI_WIDTH_AD.

Reset
REQ-023 While rst=1 at a clock edge, the state SHALL be IDLE and all outputs SHALL be 0, including bias_vec, och_mask and och_base.
REQ-024 Reset in any state SHALL abandon the layer without emitting ap_done; DMA beats arriving after reset SHALL be ignored.

Structure
REQ-025 OCH_PAR, BIAS_BITS, the AXI widths, BITS_TRANS and the state encoding SHALL live in a shared conv package.
REQ-026 The lane bias register file with its masking logic SHALL be one sub-module, seq_bias_bank; the state machine and address logic SHALL stay in the top module.

Verification
REQ-027 OCH_PAR=4, out_ch=8, base=0x1000 -> two requests: addr 0x1000 and 0x1008, num_trans 2 each; two calc_start pulses; one ap_done.
REQ-028 OCH_PAR=4, out_ch=6, beats 0x00040003 (second group) -> num_trans=1, bias_vec lanes = {0,0,4,3} (lane3..lane0), och_mask=0011, och_base=4.
REQ-029 out_ch=0 -> no start_dma and no calc_start; ap_done at T+2.
REQ-030 3 beats delivered for num_trans=2, with dma_done arriving in the same cycle as beat 2 -> third beat ignored; calc_start one cycle later.
REQ-031 ap_start repeated during GRP_RUN, and grp_done injected during BIAS_WAIT -> both ignored; the group count is unchanged.
REQ-032 rst asserted in BIAS_WAIT, then beats continue -> all outputs 0, state IDLE, no ap_done; a fresh ap_start runs the layer normally.

Source files
------------

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared conv constants and the sequencer state encoding.
package conv_layer_sequencer_pkg;

  localparam int CONV_OCH_PAR      = 4;   // output channels per group (even, >= 2)
  localparam int CONV_BIAS_BITS    = 16;  // width of one bias
  localparam int CONV_AXI_WIDTH_AD = 32;  // DMA byte-address width
  localparam int CONV_AXI_WIDTH_DA = 32;  // DMA data width, two biases per beat
  localparam int CONV_BITS_TRANS   = 18;  // DMA beat-count width
  localparam int CONV_OCH_W        = 9;   // channel-index width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BIAS_REQ  = 3'd1,
    ST_BIAS_WAIT = 3'd2,
    ST_GRP_START = 3'd3,
    ST_GRP_RUN   = 3'd4,
    ST_NEXT      = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/conv_layer_sequencer_bias.sv
// Lane bias register file: one bias per output-channel lane, with a lane-valid
// mask. Lanes outside the mask are never written and always read as zero.
module seq_bias_bank
  import conv_layer_sequencer_pkg::*;
#(
  parameter int OCH_PAR   = CONV_OCH_PAR,
  parameter int BIAS_BITS = CONV_BIAS_BITS,
  parameter int DATA_W    = CONV_AXI_WIDTH_DA,
  parameter int IDX_W     = CONV_BITS_TRANS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,    // start of a group load
  input  logic [CONV_OCH_W-1:0]        valid_i,  // lanes in use for this group
  input  logic                         wr_i,     // accepted DMA beat
  input  logic [IDX_W-1:0]             beat_i,   // index k of the beat
  input  logic [DATA_W-1:0]            data_i,
  output logic [OCH_PAR*BIAS_BITS-1:0] bias_vec_o,
  output logic [OCH_PAR-1:0]           mask_o
);

  logic [OCH_PAR-1:0][BIAS_BITS-1:0] lane_q, lane_d;
  logic [OCH_PAR-1:0]                mask_q, mask_d;

  // Clear lanes and rebuild the mask on a new load; beat k fills lanes 2k/2k+1.
  always_comb begin
    lane_d = lane_q;
    mask_d = mask_q;
    for (int i = 0; i < OCH_PAR; i++) begin
      if (clr_i) begin
        lane_d[i] = '0;
        mask_d[i] = (CONV_OCH_W'(i) < valid_i);
      end else if (wr_i && mask_q[i] && (beat_i == IDX_W'(i / 2))) begin
        if ((i % 2) == 0) lane_d[i] = data_i[BIAS_BITS-1:0];
        else              lane_d[i] = data_i[2*BIAS_BITS-1:BIAS_BITS];
      end
    end
  end

  // Lane and mask registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      mask_q <= '0;
    end else begin
      lane_q <= lane_d;
      mask_q <= mask_d;
    end
  end

  // Masked read-out: invalid lanes present zero.
  always_comb begin
    bias_vec_o = '0;
    for (int i = 0; i < OCH_PAR; i++) begin
      bias_vec_o[i*BIAS_BITS +: BIAS_BITS] = mask_q[i] ? lane_q[i] : '0;
    end
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks a layer's output channels in groups of
// OCH_PAR, fetching each group's biases over DMA before starting the datapath.
//
// DMA handshake: there is no backpressure. While in BIAS_WAIT every cycle with
// dma_din_vld=1 is one accepted beat (beats past num_trans are dropped);
// dma_done is a one-cycle completion pulse that may come before, with, or
// after the last beat. Beats or dma_done outside BIAS_WAIT are ignored.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int OCH_PAR      = CONV_OCH_PAR,
  parameter int BIAS_BITS    = CONV_BIAS_BITS,
  parameter int AXI_WIDTH_AD = CONV_AXI_WIDTH_AD,
  parameter int AXI_WIDTH_DA = CONV_AXI_WIDTH_DA,
  parameter int BITS_TRANS   = CONV_BITS_TRANS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ap_start,
  input  logic [CONV_OCH_W-1:0]        out_ch,
  input  logic [AXI_WIDTH_AD-1:0]      bias_start_addr,
  input  logic                         grp_done,
  input  logic [AXI_WIDTH_DA-1:0]      dma_din,
  input  logic                         dma_din_vld,
  input  logic                         dma_done,
  output logic                         start_dma,
  output logic [BITS_TRANS-1:0]        num_trans,
  output logic [AXI_WIDTH_AD-1:0]      start_addr,
  output logic                         dma_sel,
  output logic [OCH_PAR*BIAS_BITS-1:0] bias_vec,
  output logic [OCH_PAR-1:0]           och_mask,
  output logic [CONV_OCH_W-1:0]        och_base,
  output logic                         calc_start,
  output logic                         busy,
  output logic                         ap_done
);

  state_e                  state_q, state_d;
  logic [CONV_OCH_W-1:0]   out_ch_q, out_ch_d;
  logic [CONV_OCH_W-1:0]   och_base_q, och_base_d;
  logic [AXI_WIDTH_AD-1:0] base_q, base_d;
  logic [BITS_TRANS-1:0]   num_trans_q, num_trans_d;
  logic [BITS_TRANS-1:0]   beat_cnt_q, beat_cnt_d;
  logic                    dma_seen_q, dma_seen_d;
  logic                    zero_q, zero_d;

  logic [CONV_OCH_W-1:0]   remain, valid;
  logic [BITS_TRANS-1:0]   nt_calc;
  logic [AXI_WIDTH_AD-1:0] addr_calc;
  logic [CONV_OCH_W:0]     next_base;
  logic                    bank_clr, bank_wr;

  // Group geometry: lanes in use, beat count, and wrapping bias address.
  always_comb begin
    remain    = out_ch_q - och_base_q;
    valid     = (remain > CONV_OCH_W'(OCH_PAR)) ? CONV_OCH_W'(OCH_PAR) : remain;
    nt_calc   = BITS_TRANS'((valid + CONV_OCH_W'(1)) >> 1);
    addr_calc = base_q + AXI_WIDTH_AD'(och_base_q) * AXI_WIDTH_AD'(BIAS_BITS / 8);
    next_base = {1'b0, och_base_q} + (CONV_OCH_W+1)'(OCH_PAR);
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    out_ch_d    = out_ch_q;
    och_base_d  = och_base_q;
    base_d      = base_q;
    num_trans_d = num_trans_q;
    beat_cnt_d  = beat_cnt_q;
    dma_seen_d  = dma_seen_q;
    zero_d      = zero_q;
    bank_clr    = 1'b0;
    bank_wr     = 1'b0;
    start_dma   = 1'b0;
    num_trans   = '0;
    start_addr  = '0;
    dma_sel     = 1'b0;
    calc_start  = 1'b0;
    ap_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          out_ch_d   = out_ch;
          base_d     = bias_start_addr;
          och_base_d = '0;
          if (out_ch == '0) begin
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BIAS_REQ;
          end
        end
      end
      ST_BIAS_REQ: begin
        start_dma   = 1'b1;
        num_trans   = nt_calc;
        start_addr  = addr_calc;
        dma_sel     = 1'b1;
        bank_clr    = 1'b1;
        num_trans_d = nt_calc;
        beat_cnt_d  = '0;
        dma_seen_d  = 1'b0;
        state_d     = ST_BIAS_WAIT;
      end
      ST_BIAS_WAIT: begin
        dma_sel = 1'b1;
        if (dma_din_vld && (beat_cnt_q < num_trans_q)) begin
          bank_wr    = 1'b1;
          beat_cnt_d = beat_cnt_q + BITS_TRANS'(1);
        end
        if (dma_done) dma_seen_d = 1'b1;
        if ((dma_seen_q || dma_done) && (beat_cnt_d == num_trans_q)) begin
          state_d = ST_GRP_START;
        end
      end
      ST_GRP_START: begin
        calc_start = 1'b1;
        state_d    = ST_GRP_RUN;
      end
      ST_GRP_RUN: begin
        if (grp_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        och_base_d = next_base[CONV_OCH_W-1:0];
        if (next_base >= {1'b0, out_ch_q}) state_d = ST_DONE;
        else                              state_d = ST_BIAS_REQ;
      end
      ST_DONE: begin
        // An empty layer lingers one extra cycle here so its ap_done lands two
        // cycles after ap_start, matching the NEXT->DONE hop of a real layer.
        if (zero_q) begin
          zero_d = 1'b0;
        end else begin
          ap_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and layer-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_ch_q    <= '0;
      och_base_q  <= '0;
      base_q      <= '0;
      num_trans_q <= '0;
      beat_cnt_q  <= '0;
      dma_seen_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_ch_q    <= out_ch_d;
      och_base_q  <= och_base_d;
      base_q      <= base_d;
      num_trans_q <= num_trans_d;
      beat_cnt_q  <= beat_cnt_d;
      dma_seen_q  <= dma_seen_d;
      zero_q      <= zero_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign och_base = och_base_q;

  seq_bias_bank #(
    .OCH_PAR  (OCH_PAR),
    .BIAS_BITS(BIAS_BITS),
    .DATA_W   (AXI_WIDTH_DA),
    .IDX_W    (BITS_TRANS)
  ) u_bias_bank (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (bank_clr),
    .valid_i   (valid),
    .wr_i      (bank_wr),
    .beat_i    (beat_cnt_q),
    .data_i    (dma_din),
    .bias_vec_o(bias_vec),
    .mask_o    (och_mask)
  );

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (default parameters: 4 lanes, 16-bit biases).
module tb_conv_layer_sequencer;

  logic        clk;
  logic        rst;
  logic        ap_start;
  logic [8:0]  out_ch;
  logic [31:0] bias_start_addr;
  logic        grp_done;
  logic [31:0] dma_din;
  logic        dma_din_vld;
  logic        dma_done;
  logic        start_dma;
  logic [17:0] num_trans;
  logic [31:0] start_addr;
  logic        dma_sel;
  logic [63:0] bias_vec;
  logic [3:0]  och_mask;
  logic [8:0]  och_base;
  logic        calc_start;
  logic        busy;
  logic        ap_done;

  int n_cmp;
  int n_err;

  conv_layer_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .ap_start       (ap_start),
    .out_ch         (out_ch),
    .bias_start_addr(bias_start_addr),
    .grp_done       (grp_done),
    .dma_din        (dma_din),
    .dma_din_vld    (dma_din_vld),
    .dma_done       (dma_done),
    .start_dma      (start_dma),
    .num_trans      (num_trans),
    .start_addr     (start_addr),
    .dma_sel        (dma_sel),
    .bias_vec       (bias_vec),
    .och_mask       (och_mask),
    .och_base       (och_base),
    .calc_start     (calc_start),
    .busy           (busy),
    .ap_done        (ap_done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_layer(input logic [8:0] oc, input logic [31:0] addr);
    ap_start = 1'b1;
    out_ch = oc;
    bias_start_addr = addr;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] data, input logic done);
    dma_din = data;
    dma_din_vld = 1'b1;
    dma_done = done;
    tick();
    dma_din_vld = 1'b0;
    dma_done = 1'b0;
  endtask

  task automatic pulse_grp_done();
    grp_done = 1'b1;
    tick();
    grp_done = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ap_start = 1'b0;
    out_ch = '0;
    bias_start_addr = '0;
    grp_done = 1'b0;
    dma_din = '0;
    dma_din_vld = 1'b0;
    dma_done = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_start_dma", 64'(start_dma), 64'h0);
    check("rst_dma_sel", 64'(dma_sel), 64'h0);
    check("rst_bias_vec", bias_vec, 64'h0);
    check("rst_mask", 64'(och_mask), 64'h0);
    check("rst_och_base", 64'(och_base), 64'h0);
    check("rst_ap_done", 64'(ap_done), 64'h0);
    rst = 1'b0;
    tick();

    // out_ch=8, base 0x1000: two full groups
    start_layer(9'd8, 32'h1000);
    check("l8_g0_start_dma", 64'(start_dma), 64'h1);
    check("l8_g0_addr", 64'(start_addr), 64'h1000);
    check("l8_g0_ntrans", 64'(num_trans), 64'h2);
    check("l8_g0_dma_sel", 64'(dma_sel), 64'h1);
    tick();
    check("l8_g0_wait_sel", 64'(dma_sel), 64'h1);
    check("l8_g0_wait_dma", 64'(start_dma), 64'h0);
    check("l8_g0_mask", 64'(och_mask), 64'hF);
    beat(32'h0002_0001, 1'b0);
    beat(32'h0004_0003, 1'b1);
    check("l8_g0_calc", 64'(calc_start), 64'h1);
    check("l8_g0_bias", bias_vec, 64'h0004_0003_0002_0001);
    check("l8_g0_base", 64'(och_base), 64'h0);
    check("l8_g0_sel_off", 64'(dma_sel), 64'h0);
    tick();
    check("l8_g0_calc_pulse", 64'(calc_start), 64'h0);
    pulse_grp_done();
    check("l8_next_no_done", 64'(ap_done), 64'h0);
    tick();
    check("l8_g1_start_dma", 64'(start_dma), 64'h1);
    check("l8_g1_addr", 64'(start_addr), 64'h1008);
    check("l8_g1_ntrans", 64'(num_trans), 64'h2);
    check("l8_g1_base", 64'(och_base), 64'h4);
    tick();
    beat(32'h0006_0005, 1'b0);
    beat(32'h0008_0007, 1'b1);
    check("l8_g1_calc", 64'(calc_start), 64'h1);
    check("l8_g1_bias", bias_vec, 64'h0008_0007_0006_0005);
    tick();
    pulse_grp_done();
    check("l8_v1_no_done", 64'(ap_done), 64'h0);
    tick();
    check("l8_ap_done", 64'(ap_done), 64'h1);
    tick();
    check("l8_ap_done_pulse", 64'(ap_done), 64'h0);
    check("l8_idle", 64'(busy), 64'h0);

    // out_ch=6, base 0x2000: partial second group, dma_done before its beat
    start_layer(9'd6, 32'h2000);
    check("l6_g0_ntrans", 64'(num_trans), 64'h2);
    check("l6_g0_addr", 64'(start_addr), 64'h2000);
    tick();
    beat(32'h0002_0001, 1'b0);
    beat(32'h0004_0003, 1'b1);
    tick();
    pulse_grp_done();
    tick();
    check("l6_g1_ntrans", 64'(num_trans), 64'h1);
    check("l6_g1_addr", 64'(start_addr), 64'h2008);
    check("l6_g1_base", 64'(och_base), 64'h4);
    tick();
    check("l6_g1_mask", 64'(och_mask), 64'h3);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("l6_done_first_wait", 64'(calc_start), 64'h0);
    check("l6_done_first_sel", 64'(dma_sel), 64'h1);
    beat(32'h0004_0003, 1'b0);
    check("l6_g1_calc", 64'(calc_start), 64'h1);
    check("l6_g1_bias", bias_vec, 64'h0000_0000_0004_0003);
    check("l6_g1_mask_hold", 64'(och_mask), 64'h3);
    check("l6_g1_base_hold", 64'(och_base), 64'h4);
    tick();
    pulse_grp_done();
    tick();
    check("l6_ap_done", 64'(ap_done), 64'h1);
    tick();

    // out_ch=0: no DMA, no group, ap_done two cycles after ap_start
    start_layer(9'd0, 32'h5000);
    check("l0_no_dma", 64'(start_dma), 64'h0);
    check("l0_early_done", 64'(ap_done), 64'h0);
    check("l0_busy", 64'(busy), 64'h1);
    tick();
    check("l0_ap_done", 64'(ap_done), 64'h1);
    check("l0_no_calc", 64'(calc_start), 64'h0);
    tick();
    check("l0_idle", 64'(busy), 64'h0);
    check("l0_ap_done_pulse", 64'(ap_done), 64'h0);

    // out_ch=4: a third beat arrives after the transfer completed
    start_layer(9'd4, 32'h3000);
    check("l4_ntrans", 64'(num_trans), 64'h2);
    check("l4_addr", 64'(start_addr), 64'h3000);
    tick();
    beat(32'h0012_0011, 1'b0);
    beat(32'h0014_0013, 1'b1);
    check("l4_calc", 64'(calc_start), 64'h1);
    beat(32'h00FF_00FF, 1'b0);
    check("l4_extra_ignored", bias_vec, 64'h0014_0013_0012_0011);
    check("l4_calc_pulse", 64'(calc_start), 64'h0);

    // ap_start during GRP_RUN is ignored: layer still ends after one group
    start_layer(9'd8, 32'h9000);
    check("l4_restart_no_dma", 64'(start_dma), 64'h0);
    check("l4_restart_busy", 64'(busy), 64'h1);
    pulse_grp_done();
    tick();
    check("l4_ap_done", 64'(ap_done), 64'h1);
    tick();

    // grp_done during BIAS_WAIT is ignored
    start_layer(9'd8, 32'h4000);
    tick();
    pulse_grp_done();
    check("gd_wait_base", 64'(och_base), 64'h0);
    check("gd_wait_sel", 64'(dma_sel), 64'h1);
    check("gd_wait_calc", 64'(calc_start), 64'h0);
    beat(32'h0022_0021, 1'b0);
    beat(32'h0024_0023, 1'b1);
    check("gd_calc", 64'(calc_start), 64'h1);
    check("gd_base", 64'(och_base), 64'h0);
    tick();
    pulse_grp_done();
    tick();
    check("gd_g1_base", 64'(och_base), 64'h4);
    check("gd_g1_addr", 64'(start_addr), 64'h4008);

    // reset in BIAS_WAIT with beats still arriving
    tick();
    beat(32'h0026_0025, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_bias", bias_vec, 64'h0);
    check("mid_rst_mask", 64'(och_mask), 64'h0);
    check("mid_rst_base", 64'(och_base), 64'h0);
    check("mid_rst_sel", 64'(dma_sel), 64'h0);
    check("mid_rst_done", 64'(ap_done), 64'h0);
    rst = 1'b0;
    beat(32'h0028_0027, 1'b1);
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_calc", 64'(calc_start), 64'h0);
    check("post_rst_bias", bias_vec, 64'h0);
    tick();
    check("post_rst_no_done", 64'(ap_done), 64'h0);

    // fresh layer after reset, base near the top of the address space (wraps)
    start_layer(9'd6, 32'hFFFF_FFFC);
    check("wr_g0_addr", 64'(start_addr), 64'hFFFF_FFFC);
    check("wr_g0_ntrans", 64'(num_trans), 64'h2);
    tick();
    beat(32'h0032_0031, 1'b0);
    beat(32'h0034_0033, 1'b1);
    check("wr_g0_calc", 64'(calc_start), 64'h1);
    check("wr_g0_bias", bias_vec, 64'h0034_0033_0032_0031);
    tick();
    pulse_grp_done();
    tick();
    check("wr_g1_addr", 64'(start_addr), 64'h0000_0004);
    check("wr_g1_ntrans", 64'(num_trans), 64'h1);
    tick();
    beat(32'h0036_0035, 1'b1);
    check("wr_g1_calc", 64'(calc_start), 64'h1);
    check("wr_g1_bias", bias_vec, 64'h0000_0000_0036_0035);
    check("wr_g1_mask", 64'(och_mask), 64'h3);
    tick();
    pulse_grp_done();
    tick();
    check("wr_ap_done", 64'(ap_done), 64'h1);
    tick();
    check("wr_idle", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
